// File: rtl/stepper_ctrl.sv
// Bipolar stepper motor controller: timed half/full-step phase sequencing
// with PWM coil drive, step counting, abort and optional holding torque.
module stepper_ctrl #(
    parameter int DIV_W = 24,
    parameter int CNT_W = 16,
    parameter int PWM_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             dir,
    input  logic             half,
    input  logic [CNT_W-1:0] steps,
    input  logic [DIV_W-1:0] period,
    input  logic [PWM_W-1:0] duty,
    input  logic             hold,
    input  logic             abort,
    output logic             INA,
    output logic             INA2,
    output logic             INB,
    output logic             INB2,
    output logic             busy,
    output logic             done,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] steps_left
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic             dir_l, half_l;
    logic [DIV_W-1:0] period_l, div_cnt;
    logic [PWM_W-1:0] duty_l, pwm_cnt;
    logic             tick, done_next, accept;
    logic [2:0]       step_amt, phase_next;
    logic             coil_a, coil_a2, coil_b, coil_b2, pwm_on, drive_en;

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        accept     = 1'b0;
        tick       = (state == RUN) && (div_cnt == period_l);
        case (state)
            IDLE: begin
                if (start) begin
                    if (steps != '0) begin
                        state_next = RUN;
                        accept     = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (tick && steps_left == CNT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Full steps move between odd (two-coil) phases; an even phase first aligns by one.
    always_comb begin
        step_amt   = (half_l || !phase[0]) ? 3'd1 : 3'd2;
        phase_next = dir_l ? (phase + step_amt) : (phase - step_amt);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            done       <= 1'b0;
            phase      <= 3'd0;
            steps_left <= '0;
            div_cnt    <= '0;
            pwm_cnt    <= '0;
            duty_l     <= '0;
            period_l   <= '0;
            dir_l      <= 1'b0;
            half_l     <= 1'b0;
        end else begin
            state   <= state_next;
            done    <= done_next;
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (accept) begin
                dir_l      <= dir;
                half_l     <= half;
                steps_left <= steps;
                period_l   <= period;
                duty_l     <= duty;
                div_cnt    <= '0;
            end else if (state == RUN && !abort) begin
                if (tick) begin
                    div_cnt    <= '0;
                    phase      <= phase_next;
                    steps_left <= steps_left - CNT_W'(1);
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

    always_comb begin
        coil_a  = (phase == 3'd5) || (phase == 3'd6) || (phase == 3'd7);
        coil_a2 = (phase == 3'd1) || (phase == 3'd2) || (phase == 3'd3);
        coil_b  = (phase == 3'd3) || (phase == 3'd4) || (phase == 3'd5);
        coil_b2 = (phase == 3'd7) || (phase == 3'd0) || (phase == 3'd1);
    end

    assign busy     = (state == RUN);
    assign pwm_on   = (pwm_cnt < duty_l);
    assign drive_en = busy || hold;
    assign INA      = drive_en && pwm_on && coil_a;
    assign INA2     = drive_en && pwm_on && coil_a2;
    assign INB      = drive_en && pwm_on && coil_b;
    assign INB2     = drive_en && pwm_on && coil_b2;

endmodule
